instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage sitting directly upstream of the execute unit. It holds the program counter, issues word reads to a synchronous instruction memory with fixed 1-cycle read latency, buffers returned words in a small FIFO, and presents them to execute as a 32-bit instruction register (IR) over a valid/ready handshake. A redirect input reloads the PC and flushes all fetched-but-unconsumed instructions.

## Interface
- ADDR_W, 16: PC / instruction-memory word-address width.
- DEPTH, 2: instruction buffer entries (power of two, ≥2).
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request this cycle.
- imem_addr  out  ADDR_W  word address of the request (equals PC).
- imem_rdata  in  32  read data, valid exactly one cycle after imem_req.
- redirect_valid  in  1  load new PC and flush this cycle.
- redirect_pc  in  ADDR_W  target word address.
- ir_valid  out  1  ir_data holds a valid instruction.
- ir_ready  in  1  execute accepts ir_data this cycle.
- ir_data  out  32  instruction word; fields: oper_type [31:27], rdst [26:22], rsrc1 [21:17], imm_mode [16], rsrc2 [15:11], isrc [15:0].
- ir_pc  out  ADDR_W  address the current ir_data was fetched from.
- ir_illegal  out  1  ir_valid and oper_type > 5'b00100 (only movsgpr, mov, add, sub and mul are legal).

## Operation
- State: pc, inflight flag + inflight address, FIFO (DEPTH × {32-bit word, ADDR_W pc}), rd/wr pointers, count (0..DEPTH).
- pop = ir_valid & ir_ready. ir_valid = (count != 0).
- Issue rule: imem_req = !redirect_valid & (count + inflight − pop < DEPTH). imem_addr = pc. On issue: pc <= pc + 1 (wraps 2^ADDR_W−1 → 0); inflight <= 1 with its address latched; otherwise inflight <= 0.
- Return: if inflight was set last cycle and no redirect this cycle, push {imem_rdata, inflight address} into the FIFO.
- Redirect (redirect_valid = 1): pc <= redirect_pc; FIFO emptied (count <= 0, pointers reset); any data returning this cycle is discarded; no request issued; inflight <= 0. A pop in the same cycle still completes (execute has taken the word), then the flush applies.
- Simultaneous push and pop: count unchanged; the FIFO never overflows by construction of the issue rule.
- ir_data / ir_pc are driven from the FIFO head; when ir_valid = 0, they hold the last head value (don't-care for checking).
- ir_illegal is combinational from the head's oper_type, gated by ir_valid. Fetch does not drop illegal words; execute decides.

## Timing
- Reset (rst_n low, asynchronous): pc = 0, count = 0, inflight = 0, pointers = 0, imem_req = 0, imem_addr = 0, ir_valid = 0, ir_illegal = 0, ir_data = 0, ir_pc = 0. Assertion mid-fetch clears immediately; inflight data is lost.
- Cycle 0 = first cycle after rst_n deasserts: imem_req = 1, addr 0. Cycle 1: data returns, is pushed, addr 1 requested. Cycle 2: ir_valid = 1 with word@0.
- Fetch-to-IR latency 2 cycles; redirect-to-IR latency 3 cycles (request in cycle R+1, valid in R+3).
- With ir_ready held high, throughput is 1 instruction/cycle (DEPTH = 2).
- ir_ready low: issuing stops once count + inflight = DEPTH; no word is lost or duplicated; ir_data stays stable while ir_valid & !ir_ready.
- redirect_valid held multiple cycles: each cycle reloads pc; fetching resumes the cycle after it drops.

## Test plan
- Reset/stream: mem[i] = 32'h1000_0000 + i, ir_ready = 1 -> ir_valid first at cycle 2; ir_data = mem[0], mem[1], … on consecutive cycles; ir_pc = 0, 1, 2…; async reset mid-stream -> all outputs 0 within the same cycle.
- Backpressure: ir_ready = 0 for cycles 2–9, then 1 -> imem_req drops after 2 outstanding; words 0,1,2,… still delivered in order, none dropped or repeated; ir_data stable while stalled.
- Redirect: redirect_pc = 16'h0040 at cycle 5 with ir_ready = 1 -> the word popped in cycle 5 counts; the next ir_valid is at cycle 8 with ir_pc = 0x0040; no words from the old stream appear after cycle 5.
- Wrap: redirect to 16'hFFFF -> ir_pc sequence FFFF, 0000, 0001.
- Illegal opcode: mem[3] oper_type = 5'b00101, mem[4] = 5'b00100 -> ir_illegal = 1 only while word@3 is at the head; 0 for mul at word@4.
- Redirect during stall: FIFO full, ir_ready = 0, redirect_valid = 1 -> ir_valid = 0 the next cycle; refill from redirect_pc.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: instruction-memory read port, redirect, and IR valid/ready handshake.
// master = fetch stage, slave = the memory/execute side that surrounds it.
interface instr_fetch_if #(
  parameter int ADDR_W = 16
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              ir_valid;
  logic              ir_ready;
  logic [31:0]       ir_data;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_illegal;

  modport master (
    output imem_req, imem_addr, ir_valid, ir_data, ir_pc, ir_illegal,
    input  imem_rdata, redirect_valid, redirect_pc, ir_ready
  );

  modport slave (
    input  imem_req, imem_addr, ir_valid, ir_data, ir_pc, ir_illegal,
    output imem_rdata, redirect_valid, redirect_pc, ir_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC + 1-cycle imem reads into a DEPTH-entry buffer; fetch-to-IR 2 cycles, redirect-to-IR 3.
// Backpressure: issue stops once buffered + in-flight words reach DEPTH; redirect flushes the buffer.
module instr_fetch #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0]       word;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_addr_q, inflight_addr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];

  logic              pop, push, issue;
  logic [CW:0]       occ;
  entry_t            head;

  assign head  = mem_q[rd_ptr_q];
  assign pop   = bus.ir_valid & bus.ir_ready;
  assign push  = inflight_q & ~bus.redirect_valid;
  // Occupancy after this cycle's pop; pop implies count >= 1, so no underflow.
  assign occ   = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue = rst_n & ~bus.redirect_valid & (occ < DEPTH_C);

  assign bus.imem_req   = issue;
  assign bus.imem_addr  = pc_q;
  assign bus.ir_valid   = (count_q != '0);
  assign bus.ir_data    = head.word;
  assign bus.ir_pc      = head.pc;
  assign bus.ir_illegal = bus.ir_valid & (head.word[31:27] > 5'b00100);

  always_comb begin
    pc_d            = pc_q;
    inflight_d      = 1'b0;
    inflight_addr_d = inflight_addr_q;
    count_d         = count_q + CW'(push) - CW'(pop);
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    mem_d           = mem_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{word: bus.imem_rdata, pc: inflight_addr_q};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (issue) begin
      pc_d            = pc_q + ADDR_W'(1);
      inflight_d      = 1'b1;
      inflight_addr_d = pc_q;
    end
    // A same-cycle pop has already been taken by execute; the flush discards everything else.
    if (bus.redirect_valid) begin
      pc_d     = bus.redirect_pc;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q            <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      count_q         <= '0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pc_q            <= pc_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      count_q         <= count_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      mem_q           <= mem_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a synchronous imem model plus an expected-PC scoreboard
// that is reloaded whenever the stimulus issues a reset or redirect.
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vec = 0;
  int   miss = 0;
  int   cyc = 0;
  logic [15:0] exp_q[$];

  instr_fetch_if #(.ADDR_W(16)) bus ();

  instr_fetch #(.ADDR_W(16), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    logic [31:0] w;
    w = 32'h1000_0000 + {16'h0000, a};
    if (a == 16'd3)      w[31:27] = 5'b00101;
    else if (a == 16'd4) w[31:27] = 5'b00100;
    return w;
  endfunction

  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= mem_word(bus.imem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic load_stream(input logic [15:0] start);
    exp_q.delete();
    for (int k = 0; k < 64; k++) exp_q.push_back(start + 16'(k));
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Apply this cycle's inputs, let them settle, then score any head/pop against the queue.
  task automatic drive(input logic rdy, input logic redir, input logic [15:0] rpc);
    logic [31:0] w;
    bus.ir_ready       = rdy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    #1;
    if (bus.ir_valid === 1'b1) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        w = mem_word(exp_q[0]);
        chk("sb_illegal", 32'(bus.ir_illegal), 32'(w[31:27] > 5'b00100));
        if (rdy) begin
          chk("sb_pc", 32'(bus.ir_pc), 32'(exp_q[0]));
          chk("sb_data", bus.ir_data, w);
          void'(exp_q.pop_front());
        end
      end
    end
    if (redir) load_stream(rpc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.ir_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0000;
    #1;
    chk("rst_req",     32'(bus.imem_req),   32'd0);
    chk("rst_addr",    32'(bus.imem_addr),  32'd0);
    chk("rst_valid",   32'(bus.ir_valid),   32'd0);
    chk("rst_illegal", 32'(bus.ir_illegal), 32'd0);
    chk("rst_data",    bus.ir_data,         32'd0);
    chk("rst_pc",      32'(bus.ir_pc),      32'd0);
    adv();
    adv();
    rst_n = 1'b1;
    load_stream(16'h0000);
    cyc = 0;
  endtask

  initial begin
    // Streaming at full rate, illegal opcode at word 3, then reset mid-stream.
    do_reset();
    for (int c = 0; c < 13; c++) begin
      drive(1'b1, 1'b0, 16'h0000);
      if (c == 0) begin
        chk("c0_req",   32'(bus.imem_req),  32'd1);
        chk("c0_addr",  32'(bus.imem_addr), 32'd0);
        chk("c0_valid", 32'(bus.ir_valid),  32'd0);
      end
      if (c == 1) begin
        chk("c1_valid", 32'(bus.ir_valid),  32'd0);
        chk("c1_addr",  32'(bus.imem_addr), 32'd1);
      end
      if (c >= 2) chk("stream_valid", 32'(bus.ir_valid), 32'd1);
      if (c == 2) chk("first_pc", 32'(bus.ir_pc), 32'd0);
      if (c == 5) chk("illegal_w3", 32'(bus.ir_illegal), 32'd1);
      if (c == 6) chk("legal_w4",   32'(bus.ir_illegal), 32'd0);
      if (c < 12) adv();
    end

    // Backpressure: ready low for cycles 2..9.
    do_reset();
    for (int c = 0; c < 22; c++) begin
      drive((c < 2) || (c >= 10), 1'b0, 16'h0000);
      if (c >= 2 && c <= 9) begin
        chk("stall_req", 32'(bus.imem_req), 32'd0);
        chk("stall_data", bus.ir_data, mem_word(16'h0000));
        chk("stall_pc", 32'(bus.ir_pc), 32'd0);
      end
      if (c == 10) begin
        chk("resume_req",  32'(bus.imem_req),  32'd1);
        chk("resume_addr", 32'(bus.imem_addr), 32'd2);
      end
      if (c >= 10) chk("resume_valid", 32'(bus.ir_valid), 32'd1);
      adv();
    end

    // Redirect to 0x0040 at cycle 5, then to 0xFFFF at cycle 13 for the wrap.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, (c == 5) || (c == 13), (c == 5) ? 16'h0040 : 16'hFFFF);
      if (c == 5) begin
        chk("redir_req",    32'(bus.imem_req), 32'd0);
        chk("redir_pop_pc", 32'(bus.ir_pc),    32'd3);
      end
      if (c == 6) begin
        chk("redir_c6_valid", 32'(bus.ir_valid),  32'd0);
        chk("redir_c6_req",   32'(bus.imem_req),  32'd1);
        chk("redir_c6_addr",  32'(bus.imem_addr), 32'h40);
      end
      if (c == 7) chk("redir_c7_valid", 32'(bus.ir_valid), 32'd0);
      if (c == 8) begin
        chk("redir_c8_valid", 32'(bus.ir_valid), 32'd1);
        chk("redir_c8_pc",    32'(bus.ir_pc),    32'h40);
      end
      if (c == 14) chk("wrap_addr", 32'(bus.imem_addr), 32'hFFFF);
      if (c == 16) chk("wrap_pc0", 32'(bus.ir_pc), 32'hFFFF);
      if (c == 17) chk("wrap_pc1", 32'(bus.ir_pc), 32'h0000);
      if (c == 18) chk("wrap_pc2", 32'(bus.ir_pc), 32'h0001);
      adv();
    end

    // Redirect while full and stalled, held for two cycles with different targets.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      drive(c >= 10, (c == 5) || (c == 6), (c == 5) ? 16'h0100 : 16'h0200);
      if (c == 4) begin
        chk("full_valid", 32'(bus.ir_valid), 32'd1);
        chk("full_req",   32'(bus.imem_req), 32'd0);
      end
      if (c == 6) begin
        chk("hold_valid", 32'(bus.ir_valid), 32'd0);
        chk("hold_req",   32'(bus.imem_req), 32'd0);
      end
      if (c == 7) begin
        chk("refill_req",  32'(bus.imem_req),  32'd1);
        chk("refill_addr", 32'(bus.imem_addr), 32'h200);
      end
      if (c == 9) begin
        chk("refill_valid", 32'(bus.ir_valid), 32'd1);
        chk("refill_pc",    32'(bus.ir_pc),    32'h200);
      end
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
